// File: rtl/rle_run_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : rle_run_sequencer_pkg
// Desc     : Shared state encoding and default widths for the RLE front-end.
// Revision : 1.0 - initial release
// ============================================================================
package rle_run_sequencer_pkg;

    localparam int c_DW_DEFAULT      = 8;
    localparam int c_CW_DEFAULT      = 8;
    localparam int c_MAX_RUN_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        EMIT  = 2'd2,
        FLUSH = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rle_run_counter.sv
`default_nettype none
// ============================================================================
// Module   : rle_run_counter
// Desc     : Run-length counter with clear, load-one and saturating increment.
// Revision : 1.0 - initial release
// ============================================================================
module rle_run_counter
    import rle_run_sequencer_pkg::*;
#(
    parameter int CW      = c_CW_DEFAULT,
    parameter int MAX_RUN = c_MAX_RUN_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load_one_i,
    input  logic          inc_i,
    input  logic          clr_i,
    output logic [CW-1:0] count_o,
    output logic          at_max_o
);

    localparam logic [CW-1:0] c_MAX = CW'(MAX_RUN);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign count_o  = count_q;
    assign at_max_o = (count_q == c_MAX);

    // The at_max guard keeps the count from ever wrapping past MAX_RUN.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_one_i) begin
            count_d = CW'(1);
        end else if (inc_i && !at_max_o) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rle_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rle_run_sequencer
// Desc     : Byte-stream run-length front-end emitting {symbol, length} pairs.
// Revision : 1.0 - initial release
// ============================================================================
module rle_run_sequencer
    import rle_run_sequencer_pkg::*;
#(
    parameter int DW      = c_DW_DEFAULT,
    parameter int CW      = c_CW_DEFAULT,
    parameter int MAX_RUN = c_MAX_RUN_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_sym,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_sym,
    output logic [CW-1:0] out_len,
    output logic          out_last,
    output logic          busy
);

    state_t        state_q, state_d;
    logic [DW-1:0] run_sym_q, run_sym_d;
    logic          pend_last_q, pend_last_d;
    logic [DW-1:0] out_sym_q, out_sym_d;
    logic [CW-1:0] out_len_q, out_len_d;
    logic          out_last_q, out_last_d;

    logic          w_in_acc;
    logic          w_out_acc;
    logic          w_cnt_load;
    logic          w_cnt_inc;
    logic          w_cnt_clr;
    logic          w_at_max;
    logic [CW-1:0] w_run_cnt;

    assign in_ready  = (state_q == IDLE) || (state_q == RUN);
    assign out_valid = (state_q == EMIT) || (state_q == FLUSH);
    assign busy      = (state_q != IDLE);
    assign w_in_acc  = in_valid & in_ready;
    assign w_out_acc = out_valid & out_ready;
    assign out_sym   = out_sym_q;
    assign out_len   = out_len_q;
    assign out_last  = out_last_q;

    rle_run_counter #(
        .CW      (CW),
        .MAX_RUN (MAX_RUN)
    ) u_counter (
        .clock      (clock),
        .reset      (reset),
        .load_one_i (w_cnt_load),
        .inc_i      (w_cnt_inc),
        .clr_i      (w_cnt_clr),
        .count_o    (w_run_cnt),
        .at_max_o   (w_at_max)
    );

    // Entering FLUSH loads the output register with the run value it will
    // hold after this edge, so the pair is valid the very next cycle.
    always_comb begin
        state_d     = state_q;
        run_sym_d   = run_sym_q;
        pend_last_d = pend_last_q;
        out_sym_d   = out_sym_q;
        out_len_d   = out_len_q;
        out_last_d  = out_last_q;
        w_cnt_load  = 1'b0;
        w_cnt_inc   = 1'b0;
        w_cnt_clr   = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_in_acc) begin
                    run_sym_d  = in_sym;
                    w_cnt_load = 1'b1;
                    if (in_last) begin
                        out_sym_d  = in_sym;
                        out_len_d  = CW'(1);
                        out_last_d = 1'b1;
                        state_d    = FLUSH;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (w_in_acc) begin
                    if ((in_sym == run_sym_q) && !w_at_max) begin
                        w_cnt_inc = 1'b1;
                        if (in_last) begin
                            out_sym_d  = run_sym_q;
                            out_len_d  = w_run_cnt + CW'(1);
                            out_last_d = 1'b1;
                            state_d    = FLUSH;
                        end
                    end else begin
                        out_sym_d   = run_sym_q;
                        out_len_d   = w_run_cnt;
                        out_last_d  = 1'b0;
                        run_sym_d   = in_sym;
                        w_cnt_load  = 1'b1;
                        pend_last_d = in_last;
                        state_d     = EMIT;
                    end
                end
            end
            EMIT: begin
                if (w_out_acc) begin
                    pend_last_d = 1'b0;
                    if (pend_last_q) begin
                        out_sym_d  = run_sym_q;
                        out_len_d  = w_run_cnt;
                        out_last_d = 1'b1;
                        state_d    = FLUSH;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            FLUSH: begin
                if (w_out_acc) begin
                    w_cnt_clr = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            run_sym_q   <= '0;
            pend_last_q <= 1'b0;
            out_sym_q   <= '0;
            out_len_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_sym_q   <= run_sym_d;
            pend_last_q <= pend_last_d;
            out_sym_q   <= out_sym_d;
            out_len_q   <= out_len_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule
`default_nettype wire
